// File: rtl/mbq_pkg.sv
// Shared definitions for the multi-buffer queue: buffer ownership encoding
// and a constant-evaluable ceil(log2) used to size counters and lengths.
package mbq_pkg;

   // Per-buffer ownership bit
   localparam logic BUF_FREE = 1'b0;
   localparam logic BUF_FULL = 1'b1;

   // ceil(log2(value)); bits needed to hold 0..value-1
   function automatic int clog2_f(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ram_block.sv
// Simple dual-port RAM bank: synchronous write, registered read with one
// cycle of latency. Contents are not reset.
module ram_block #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Write port and registered read port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) q <= mem[raddr];
   end

endmodule

// File: rtl/multi_buffer_queue.sv
// Packet-granular FIFO built from BUFF_NUM RAM banks. The producer fills
// whole buffers (committed on wr_last or when a buffer fills); the consumer
// drains committed buffers in order through a 2-entry output stage that
// hides the RAM read latency and sustains one word per cycle.
module multi_buffer_queue
   import mbq_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 10,
   parameter int BUFF_NUM   = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              wr_valid,
   output logic                              wr_ready,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic                              wr_last,
   output logic                              rd_valid,
   input  logic                              rd_ready,
   output logic [DATA_WIDTH-1:0]             rd_data,
   output logic                              rd_last,
   output logic [clog2_f(BUFF_NUM+1)-1:0]    full_count
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int BUF_W = clog2_f(BUFF_NUM);
   localparam int CNT_W = clog2_f(BUFF_NUM + 1);
   localparam int LEN_W = clog2_f(DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   // Buffer ownership and lengths
   logic [BUFF_NUM-1:0]   state;
   logic [LEN_W-1:0]      len [BUFF_NUM];

   // Write and read pointers
   logic [BUF_W-1:0]      wr_buf;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [BUF_W-1:0]      rd_buf;
   logic [ADDR_WIDTH-1:0] rd_addr;

   // Handshake and issue decode
   logic                  wr_fire;
   logic                  commit;
   logic                  pop;
   logic                  issue;
   logic                  issue_last;
   logic [LEN_W-1:0]      rd_len;
   logic [2:0]            demand;

   // Read pipeline: issue is stage p0, RAM output is stage p1
   logic                  vld_p1;
   logic                  last_p1;
   logic [BUF_W-1:0]      buf_p1;
   logic [DATA_WIDTH-1:0] ram_q [BUFF_NUM];
   logic [DATA_WIDTH-1:0] data_p1;

   // 2-entry output stage
   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic                  fifo_last [2];
   logic                  head;
   logic                  tail;
   logic [1:0]            occ;

   // Write-side and read-side control decode
   always_comb begin
      wr_ready   = (state[wr_buf] == BUF_FREE) && !flush;
      wr_fire    = wr_valid && wr_ready;
      commit     = wr_fire && (wr_last || (wr_addr == ADDR_LAST));
      rd_valid   = (occ != 2'd0);
      pop        = rd_valid && rd_ready;
      rd_len     = len[rd_buf];
      // Entries the output stage will hold once the in-flight read lands;
      // pop implies occ >= 1, so this never underflows.
      demand     = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
      issue      = (state[rd_buf] == BUF_FULL) && (demand < 3'd2) && !flush;
      issue_last = issue && (({1'b0, rd_addr} + LEN_W'(1)) == rd_len);
   end

   // Buffer ownership, pointers and committed-buffer count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= '0;
         wr_buf     <= '0;
         wr_addr    <= '0;
         rd_buf     <= '0;
         rd_addr    <= '0;
         full_count <= '0;
      end else if (flush) begin
         state      <= '0;
         wr_buf     <= '0;
         wr_addr    <= '0;
         rd_buf     <= '0;
         rd_addr    <= '0;
         full_count <= '0;
      end else begin
         if (wr_fire) begin
            if (commit) begin
               state[wr_buf] <= BUF_FULL;
               wr_buf        <= wr_buf + BUF_W'(1);
               wr_addr       <= '0;
            end else begin
               wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end
         end
         // A FULL buffer is never the FREE write target, so these bits differ
         if (issue) begin
            if (issue_last) begin
               state[rd_buf] <= BUF_FREE;
               rd_buf        <= rd_buf + BUF_W'(1);
               rd_addr       <= '0;
            end else begin
               rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end
         end
         case ({commit, issue_last})
            2'b10:   full_count <= full_count + CNT_W'(1);
            2'b01:   full_count <= full_count - CNT_W'(1);
            default: full_count <= full_count;
         endcase
      end
   end

   // Length of each buffer, captured on commit (only read while FULL)
   always_ff @(posedge clk) begin
      if (commit) len[wr_buf] <= {1'b0, wr_addr} + LEN_W'(1);
   end

   // One RAM bank per buffer, enables decoded from the buffer index
   for (genvar i = 0; i < BUFF_NUM; i++) begin : g_bank
      ram_block #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_ram (
         .clk   (clk),
         .we    (wr_fire && (wr_buf == BUF_W'(i))),
         .waddr (wr_addr),
         .wdata (wr_data),
         .re    (issue && (rd_buf == BUF_W'(i))),
         .raddr (rd_addr),
         .q     (ram_q[i])
      );
   end

   // ---- stage p0 -> p1: read issued, RAM output valid next cycle ----
   // Track the in-flight read and which bank/last tag it belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         buf_p1  <= '0;
      end else if (flush) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         buf_p1  <= '0;
      end else begin
         vld_p1  <= issue;
         last_p1 <= issue_last;
         buf_p1  <= rd_buf;
      end
   end

   // Select the bank that answered the in-flight read
   always_comb begin
      data_p1 = ram_q[buf_p1];
   end

   // ---- stage p1 -> output stage: RAM word captured into the 2-entry FIFO ----
   // Output stage occupancy and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= 1'b0;
         tail <= 1'b0;
         occ  <= 2'd0;
      end else if (flush) begin
         head <= 1'b0;
         tail <= 1'b0;
         occ  <= 2'd0;
      end else begin
         if (vld_p1) tail <= ~tail;
         if (pop)    head <= ~head;
         occ <= occ + {1'b0, vld_p1} - {1'b0, pop};
      end
   end

   // Output stage storage
   always_ff @(posedge clk) begin
      if (vld_p1) begin
         fifo_data[tail] <= data_p1;
         fifo_last[tail] <= last_p1;
      end
   end

   // Head entry drives the consumer port; zero while empty
   always_comb begin
      rd_data = rd_valid ? fifo_data[head] : '0;
      rd_last = rd_valid && fifo_last[head];
   end

endmodule
